// File: rtl/sim_control.sv
// Simulation control device: an OCP slave with one 32-bit control register.
// Writing bit 0 = 1 ends the simulation; bit 31 selects normal or error status.
module sim_control (
  input  logic        clk,
  input  logic        nrst,
  input  logic [31:0] i_MAddr,
  input  logic [2:0]  i_MCmd,
  input  logic [31:0] i_MData,
  input  logic [3:0]  i_MByteEn,
  output logic        o_SCmdAccept,
  output logic [31:0] o_SData,
  output logic [1:0]  o_SResp
);

  localparam logic [2:0] CMD_IDLE    = 3'd0;
  localparam logic [2:0] CMD_WR      = 3'd1;
  localparam logic [2:0] CMD_RD      = 3'd2;
  localparam logic [1:0] RESP_NULL   = 2'd0;
  localparam logic [1:0] RESP_DVA    = 2'd1;
  localparam logic [1:0] RESP_ERR    = 2'd3;
  localparam logic [9:0] CTRLREG_IDX = 10'd0;

  logic [31:0] r_ctrl;
  logic [31:0] r_sdata;
  logic [1:0]  r_sresp;
  logic [31:0] w_ctrl_next;
  logic        w_hit;
  logic        w_wr_ctrl;
  logic        w_rd_ctrl;
  logic        w_trigger;
  logic        w_unused;

  // Only word index [11:2] is decoded; the rest of the address is don't-care.
  assign w_hit     = (i_MAddr[11:2] == CTRLREG_IDX);
  assign w_wr_ctrl = (i_MCmd == CMD_WR) && w_hit;
  assign w_rd_ctrl = (i_MCmd == CMD_RD) && w_hit;
  assign w_trigger = w_wr_ctrl && i_MByteEn[0] && i_MData[0];
  assign w_unused  = ^{i_MAddr[31:12], i_MAddr[1:0]};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
      assign w_ctrl_next[8*gi +: 8] = i_MByteEn[gi] ? i_MData[8*gi +: 8]
                                                     : r_ctrl[8*gi +: 8];
    end
  endgenerate

  assign o_SCmdAccept = nrst && (i_MCmd != CMD_IDLE);
  assign o_SData      = r_sdata;
  assign o_SResp      = r_sresp;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_ctrl  <= '0;
      r_sdata <= '0;
      r_sresp <= RESP_NULL;
    end else begin
      if (w_wr_ctrl) begin
        r_ctrl <= w_ctrl_next;
      end
      r_sdata <= w_rd_ctrl ? r_ctrl : '0;
      case (i_MCmd)
        CMD_IDLE:       r_sresp <= RESP_NULL;
        CMD_WR, CMD_RD: r_sresp <= RESP_DVA;
        default:        r_sresp <= RESP_ERR;
      endcase
    end
  end

`ifndef SYNTHESIS
  logic r_trig;
  logic r_finish;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_trig   <= 1'b0;
      r_finish <= 1'b0;
    end else begin
      r_trig   <= w_trigger;
      r_finish <= r_trig;
    end
  end

  always @(posedge clk) begin
    if (nrst && w_trigger) begin
      if (w_ctrl_next[31])
        $display("[%0t] Simulation finished: ERROR termination", $time);
      else
        $display("[%0t] Simulation finished: normal termination", $time);
    end
  end

  // Stop half a cycle after the DVA edge so the master has sampled the response.
  always @(negedge clk) begin
    if (r_finish) $finish;
  end
`endif

endmodule

// File: tb/tb_sim_control.sv
// Bench for sim_control: a per-cycle OCP response model plus directed
// vectors with hand-computed register values; ends on the device's own $finish.
module tb_sim_control;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [31:0] addr = '0;
  logic [2:0]  cmd = 3'd2;
  logic [31:0] data = '0;
  logic [3:0]  be = '0;
  logic        s_acc;
  logic [31:0] s_data;
  logic [1:0]  s_resp;

  int checks = 0;
  int failures = 0;

  logic [31:0] m_reg = '0;
  logic [31:0] e_data = '0;
  logic [1:0]  e_resp = '0;
  logic [31:0] m_mask;
  bit          finish_expected = 1'b0;
  longint      exp_finish_time = 0;

  sim_control dut (
    .clk          (clk),
    .nrst         (nrst),
    .i_MAddr      (addr),
    .i_MCmd       (cmd),
    .i_MData      (data),
    .i_MByteEn    (be),
    .o_SCmdAccept (s_acc),
    .o_SData      (s_data),
    .o_SResp      (s_resp)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: what one OCP command at this edge must produce on the next cycle.
  always @(posedge clk) begin
    if (!nrst) begin
      m_reg  = '0;
      e_resp = 2'd0;
      e_data = '0;
    end else begin
      e_data = '0;
      case (cmd)
        3'd0: e_resp = 2'd0;
        3'd1: begin
          e_resp = 2'd1;
          if (addr[11:2] == 10'd0) begin
            m_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
            m_reg  = (m_reg & ~m_mask) | (data & m_mask);
            if (be[0] && data[0]) begin
              finish_expected = 1'b1;
              exp_finish_time = longint'($time) + 15;
            end
          end
        end
        3'd2: begin
          e_resp = 2'd1;
          e_data = (addr[11:2] == 10'd0) ? m_reg : '0;
        end
        default: e_resp = 2'd3;
      endcase
    end
    #2;
    cmp("accept", {31'd0, s_acc}, {31'd0, (nrst && cmd != 3'd0)});
    cmp("resp", {30'd0, s_resp}, {30'd0, e_resp});
    cmp("data", s_data, e_data);
  end

  // Drive one command at a negedge; returns at the negedge of its response cycle.
  task automatic op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] b);
    cmd = c; addr = a; data = d; be = b;
    $display("[%0t] op cmd=%0d addr=0x%08h data=0x%08h be=0x%h", $time, c, a, d, b);
    @(negedge clk);
  endtask

  initial begin
    repeat (5) @(negedge clk);
    cmd = 3'd1; data = 32'h0000_0001; be = 4'hF;   // trigger held during reset
    repeat (5) @(negedge clk);
    cmp("rst_acc", {31'd0, s_acc}, 32'd0);
    cmp("rst_resp", {30'd0, s_resp}, 32'd0);
    cmp("rst_data", s_data, 32'd0);
    nrst = 1'b1;

    op(3'd1, 32'h0, 32'h000F_FFF0, 4'hF);
    cmp("wr_dva", {30'd0, s_resp}, 32'd1);
    op(3'd0, 32'h0, 32'h0, 4'h0);
    cmp("idle_null", {30'd0, s_resp}, 32'd0);
    op(3'd2, 32'h0, 32'h0, 4'h0);
    cmp("rd_scratch", s_data, 32'h000F_FFF0);
    op(3'd0, 32'h0, 32'h0, 4'h0);
    cmp("idle_data0", s_data, 32'd0);

    op(3'd1, 32'h0, 32'hAABB_CCDE, 4'h2);
    op(3'd2, 32'h0, 32'h0, 4'hF);
    cmp("rd_be2", s_data, 32'h000F_CCF0);
    op(3'd2, 32'h4, 32'h0, 4'hF);
    cmp("rd_unmapped", s_data, 32'd0);
    cmp("rd_unmapped_dva", {30'd0, s_resp}, 32'd1);

    op(3'd3, 32'h0, 32'hFFFF_FFFF, 4'hF);
    cmp("cmd3_err", {30'd0, s_resp}, 32'd3);
    op(3'd7, 32'h0, 32'hFFFF_FFFF, 4'hF);
    cmp("cmd7_err", {30'd0, s_resp}, 32'd3);
    op(3'd2, 32'h0, 32'h0, 4'h0);
    cmp("rd_after_err", s_data, 32'h000F_CCF0);

    op(3'd1, 32'h0, 32'h1234_5678, 4'hC);
    op(3'd2, 32'h0, 32'h0, 4'h0);
    cmp("rd_be_c", s_data, 32'h1234_CCF0);
    op(3'd1, 32'h0, 32'h0000_0001, 4'h2);          // bit0 set but byte 0 disabled
    op(3'd2, 32'h0, 32'h0, 4'h0);
    cmp("rd_bit0_masked", s_data, 32'h1234_00F0);
    op(3'd1, 32'h8, 32'h0000_0001, 4'hF);          // unmapped, must not trigger
    op(3'd2, 32'h0, 32'h0, 4'h0);
    cmp("rd_after_unmapped_wr", s_data, 32'h1234_00F0);
    op(3'd1, 32'h0, 32'h8000_0000, 4'h8);          // bit31 with bit0=0: no finish
    op(3'd2, 32'h0, 32'h0, 4'h0);
    cmp("rd_bit31", s_data, 32'h8034_00F0);

    nrst = 1'b0;
    #1;
    cmp("async_rst_resp", {30'd0, s_resp}, 32'd0);
    cmp("async_rst_data", s_data, 32'd0);
    cmp("async_rst_acc", {31'd0, s_acc}, 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    op(3'd2, 32'h0, 32'h0, 4'h0);
    cmp("rd_after_rst", s_data, 32'd0);
    cmp("rd_after_rst_dva", {30'd0, s_resp}, 32'd1);

    op(3'd1, 32'h0, 32'h8000_0000, 4'h8);
    op(3'd2, 32'h0, 32'h0, 4'h0);
    cmp("rd_err_bit", s_data, 32'h8000_0000);

    op(3'd1, 32'h0, 32'h0000_0001, 4'hF);          // normal termination
    cmp("term_dva", {30'd0, s_resp}, 32'd1);
    cmd = 3'd0; data = '0; be = '0;
    repeat (10) @(posedge clk);
    failures++;
    $display("FAIL term_timeout actual=running required=finished at t=%0t", $time);
    $finish;
  end

  final begin
    checks++;
    if (!finish_expected || longint'($time) != exp_finish_time) begin
      failures++;
      $display("FAIL finish_time actual=%0t required=%0d armed=%0b",
               $time, exp_finish_time, finish_expected);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
  end

endmodule
